// File: rtl/reduce_pkg.sv
// reduce_pkg: flit field layout, opcodes and the table-index derivation
// shared by the issue arbiter and the reduce unit.
package reduce_pkg;
    localparam int FlitWidth    = 82;
    localparam int ValidBitPos  = 81;
    localparam int DstPos       = 72;
    localparam int TagPos       = 38;
    localparam int OpPos        = 32;
    localparam int ChildrenPos  = 82;
    localparam int AdderLatency = 4;
    localparam logic [3:0] ShortAllReduce = 4'b1110;

    // Off-node short all-reduce flits are tracked by destination z, everything else by tag.
    function automatic logic [7:0] reduce_index(input logic [FlitWidth-1:0] f, input logic [8:0] coord);
        return (f[DstPos+:9] != coord && f[OpPos+:4] == ShortAllReduce) ? 8'(f[DstPos+6+:3]) : f[TagPos+:8];
    endfunction

    function automatic logic is_reduction(input logic [FlitWidth-1:0] f);
        return f[ValidBitPos] && f[OpPos+2+:2] == 2'b11;
    endfunction
endpackage

// File: rtl/reduce_rr_pick.sv
// reduce_rr_pick: rotate-priority picker, first eligible port at or after ptr wins.
module reduce_rr_pick #(
    parameter int NumPorts = 4,
    localparam int PW = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] eligible,
    input  logic [PW-1:0]       ptr,
    output logic [NumPorts-1:0] grant,
    output logic [PW-1:0]       grant_idx,
    output logic                any_grant
);
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        // Scan downward so the lowest offset from ptr is the last to overwrite.
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (eligible[(int'(ptr) + i) % NumPorts]) begin
                any_grant = 1'b1;
                grant_idx = PW'((int'(ptr) + i) % NumPorts);
            end
        end
        grant = any_grant ? NumPorts'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/reduce_issue_arbiter.sv
// reduce_issue_arbiter: round-robin issue of FIFO heads into the reduce unit with
// per-index hazard cooldown and a registered bypass; REDUCE_ARB_STATS_EN adds counters.
module reduce_issue_arbiter import reduce_pkg::*; #(
    parameter int NumPorts = 4,
    parameter logic [2:0] rank_z = 3'b0,
    parameter logic [2:0] rank_y = 3'b0,
    parameter logic [2:0] rank_x = 3'b0,
    parameter int lg_numprocs = 3,
    parameter int PayloadWidth = 32,
    parameter int IdxWidth = 3,
    parameter int HazardGap = AdderLatency + 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NumPorts*(lg_numprocs+FlitWidth)-1:0]   in_flit,
    input  logic [NumPorts-1:0]                           in_empty,
    output logic [NumPorts-1:0]                           in_rd_en,
    input  logic                                          ru_ready,
    output logic [lg_numprocs+FlitWidth-1:0]              ru_flit,
    output logic                                          ru_valid,
    output logic [FlitWidth-1:0]                          byp_flit,
    output logic                                          byp_valid,
    input  logic                                          byp_ready,
`ifdef REDUCE_ARB_STATS_EN
    input  logic [2:0]                                    stat_sel,
    output logic [15:0]                                   stat_count,
    output logic [15:0]                                   hazard_stall_cnt,
`endif
    output logic                                          busy
);
    localparam int EW = lg_numprocs + FlitWidth;
    localparam int PW = $clog2(NumPorts);
    localparam int Slots = 2 ** IdxWidth;
    localparam int CW = $clog2(HazardGap);
    localparam logic [8:0] Coord = {rank_z, rank_y, rank_x};

    if (PayloadWidth != OpPos) begin : g_payload_check
        $error("payload must end where the opcode field begins");
    end

    logic [EW-1:0] head [NumPorts];
    logic [IdxWidth-1:0] idx [NumPorts];
    logic [NumPorts-1:0] red, eligible, grant;
    logic [PW-1:0] ptr, gidx;
    logic any_grant, red_grant, byp_grant;
    logic [CW-1:0] cooldown [Slots];

    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            head[i] = in_flit[i*EW+:EW];
            idx[i] = IdxWidth'(reduce_index(head[i][FlitWidth-1:0], Coord));
            red[i] = is_reduction(head[i][FlitWidth-1:0]);
            eligible[i] = !rst && !in_empty[i] && (!head[i][ValidBitPos] ||
                          (red[i] ? ru_ready && cooldown[idx[i]] == '0 : !byp_valid || byp_ready));
        end
    end

    reduce_rr_pick #(.NumPorts(NumPorts)) u_pick (
        .eligible(eligible),
        .ptr(ptr),
        .grant(grant),
        .grant_idx(gidx),
        .any_grant(any_grant)
    );

    assign in_rd_en = grant;
    assign red_grant = any_grant && red[gidx];
    assign byp_grant = any_grant && head[gidx][ValidBitPos] && !red[gidx];

    always_comb begin
        busy = byp_valid;
        for (int s = 0; s < Slots; s++) busy = busy || cooldown[s] != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            ru_flit <= '0;
            ru_valid <= 1'b0;
            byp_flit <= '0;
            byp_valid <= 1'b0;
            for (int s = 0; s < Slots; s++) cooldown[s] <= '0;
        end else begin
            if (any_grant) ptr <= gidx == PW'(NumPorts - 1) ? '0 : gidx + 1'b1;
            ru_valid <= red_grant;
            // Idle cycles only drop the valid bit; the rest of the last packet holds.
            ru_flit <= red_grant ? head[gidx] : ru_flit & ~(EW'(1) << ValidBitPos);
            if (byp_grant) byp_flit <= head[gidx][ChildrenPos-1:0];
            byp_valid <= byp_grant || (byp_valid && !byp_ready);
            for (int s = 0; s < Slots; s++)
                cooldown[s] <= red_grant && idx[gidx] == IdxWidth'(s) ? CW'(HazardGap - 1)
                               : cooldown[s] - CW'(cooldown[s] != '0);
        end
    end

`ifdef REDUCE_ARB_STATS_EN
    logic [15:0] grant_cnt [NumPorts];
    logic stall;

    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NumPorts; i++)
            stall = stall || (!in_empty[i] && red[i] && ru_ready && cooldown[idx[i]] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumPorts; i++) grant_cnt[i] <= '0;
            stat_count <= '0;
            hazard_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NumPorts; i++)
                grant_cnt[i] <= grant_cnt[i] + 16'(grant[i] && grant_cnt[i] != '1);
            stat_count <= 32'(stat_sel) < NumPorts ? grant_cnt[stat_sel[PW-1:0]] : '0;
            hazard_stall_cnt <= hazard_stall_cnt + 16'(stall && hazard_stall_cnt != '1);
        end
    end
`endif
endmodule
